// File: rtl/multi_debounce.sv
// multi_debounce: NCH independent button channels. Each channel synchronises
// its raw input, debounces it with a consecutive-difference counter, and
// produces edge pulses plus a long-press pulse and an optional auto-repeat
// pulse train while the button stays held.
module multi_debounce #(
   parameter int NCH          = 4,
   parameter int SYNC_STAGES  = 3,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int HOLD_CYC     = 50000000,
   parameter int REPEAT_CYC   = 10000000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] btn_in,
   output logic [NCH-1:0] btn_out,
   output logic [NCH-1:0] btn_posedge,
   output logic [NCH-1:0] btn_negedge,
   output logic [NCH-1:0] btn_long,
   output logic [NCH-1:0] btn_repeat
);

   // Debounce counter holds 0..DEBOUNCE_CYC-1.
   localparam int DW = $clog2(DEBOUNCE_CYC);
   // Hold counter holds 0..HOLD_CYC and saturates there.
   localparam int HW = $clog2(HOLD_CYC + 1);
   // Repeat counter holds 0..REPEAT_CYC-1; one bit when repeat is disabled.
   localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_CYC - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC);
   localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   s;
         logic [DW-1:0]          deb_q, deb_d;
         logic                   out_q, out_d;
         logic [HW-1:0]          hold_q, hold_d;
         logic [RW-1:0]          rep_q, rep_d;
         logic                   pos_q, pos_d;
         logic                   neg_q, neg_d;
         logic                   long_q, long_d;
         logic                   rpt_q, rpt_d;

         // Synchroniser chain: raw level shifts in at bit 0, s is the last stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[gi]};
            end
         end

         assign s = sync_q[SYNC_STAGES-1];

         // Debounce, hold and repeat next-state logic for this channel.
         always_comb begin
            deb_d  = '0;
            out_d  = out_q;
            hold_d = '0;
            rep_d  = '0;
            long_d = 1'b0;
            rpt_d  = 1'b0;

            // A difference must persist for DEBOUNCE_CYC sampled cycles;
            // any cycle of agreement restarts the count from zero.
            if (s != out_q) begin
               if (deb_q == DEB_LAST) begin
                  out_d = ~out_q;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end

            pos_d = out_d & ~out_q;
            neg_d = ~out_d & out_q;

            // Hold/repeat only run while the debounced level stays high; a
            // falling output leaves them at zero, which also swallows any
            // long or repeat pulse due on that same cycle.
            if (out_d) begin
               if (!out_q) begin
                  // Press-accept cycle: counting starts at 1, never a long pulse here.
                  hold_d = HOLD_ONE;
               end else if (hold_q == HOLD_MAX) begin
                  hold_d = hold_q;
                  if (REPEAT_CYC > 0) begin
                     if (rep_q == REP_LAST) begin
                        rpt_d = 1'b1;
                     end else begin
                        rep_d = rep_q + 1'b1;
                     end
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
                  long_d = (hold_q == HOLD_PRE);
               end
            end
         end

         // Channel state and registered pulse outputs.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               deb_q  <= '0;
               out_q  <= 1'b0;
               hold_q <= '0;
               rep_q  <= '0;
               pos_q  <= 1'b0;
               neg_q  <= 1'b0;
               long_q <= 1'b0;
               rpt_q  <= 1'b0;
            end else begin
               deb_q  <= deb_d;
               out_q  <= out_d;
               hold_q <= hold_d;
               rep_q  <= rep_d;
               pos_q  <= pos_d;
               neg_q  <= neg_d;
               long_q <= long_d;
               rpt_q  <= rpt_d;
            end
         end

         assign btn_out[gi]     = out_q;
         assign btn_posedge[gi] = pos_q;
         assign btn_negedge[gi] = neg_q;
         assign btn_long[gi]    = long_q;
         assign btn_repeat[gi]  = rpt_q;
      end
   endgenerate

endmodule

// File: tb/tb_multi_debounce.sv
// Testbench for multi_debounce with NCH=4, SYNC_STAGES=2, DEBOUNCE_CYC=8,
// HOLD_CYC=20, REPEAT_CYC=5. Cycle c is the interval after the c-th rising
// edge of a scenario; inputs change 1 time unit after that edge and outputs
// are sampled on the following falling edge.
module tb_multi_debounce;
   localparam int NCH  = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 20;
   localparam int REP  = 5;

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b0;
   logic [NCH-1:0] btn_in = '0;
   logic [NCH-1:0] btn_out, btn_posedge, btn_negedge, btn_long, btn_repeat;

   multi_debounce #(
      .NCH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB),
      .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
      .btn_out(btn_out), .btn_posedge(btn_posedge), .btn_negedge(btn_negedge),
      .btn_long(btn_long), .btn_repeat(btn_repeat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         sid;
      int         cyc;
      logic       drv;
      logic [3:0] in_v;
      logic [3:0] out_v;
      logic [3:0] pos_v;
      logic [3:0] neg_v;
      logic [3:0] lng_v;
      logic [3:0] rep_v;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   pos_cnt[4], neg_cnt[4], lng_cnt[4], rep_cnt[4];

   function automatic logic [19:0] snap();
      return {btn_out, btn_posedge, btn_negedge, btn_long, btn_repeat};
   endfunction

   task automatic chk(input string name, input int sid, input int cyc,
                      input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s s%0d c%0d actual out/pos/neg/long/rep=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
                  name, sid, cyc, act[19:16], act[15:12], act[11:8], act[7:4], act[3:0],
                  exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
      end else begin
         $display("chk %s s%0d c%0d value=%h ok", name, sid, cyc, act);
      end
   endtask

   task automatic add(input int sid, input int cyc, input logic drv, input logic [3:0] in_v,
                      input logic [3:0] out_v, input logic [3:0] pos_v, input logic [3:0] neg_v,
                      input logic [3:0] lng_v, input logic [3:0] rep_v);
      vec_t v;
      v.sid = sid; v.cyc = cyc; v.drv = drv; v.in_v = in_v;
      v.out_v = out_v; v.pos_v = pos_v; v.neg_v = neg_v; v.lng_v = lng_v; v.rep_v = rep_v;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      btn_in = '0;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   function automatic logic [15:0] pack(input int cnt[4]);
      logic [15:0] r;
      r = '0;
      for (int ch = 0; ch < 4; ch++) r[ch*4 +: 4] = cnt[ch][3:0];
      return r;
   endfunction

   task automatic run_scenario(input int sid, input int ncyc, input logic [15:0] exp_pos,
                               input logic [15:0] exp_neg, input logic [15:0] exp_lng,
                               input logic [15:0] exp_rep);
      for (int ch = 0; ch < 4; ch++) begin
         pos_cnt[ch] = 0; neg_cnt[ch] = 0; lng_cnt[ch] = 0; rep_cnt[ch] = 0;
      end
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         foreach (vecs[i]) begin
            if (vecs[i].sid == sid && vecs[i].cyc == c && vecs[i].drv) btn_in = vecs[i].in_v;
         end
         @(negedge clk);
         foreach (vecs[i]) begin
            if (vecs[i].sid == sid && vecs[i].cyc == c) begin
               chk("vec", sid, c, snap(),
                   {vecs[i].out_v, vecs[i].pos_v, vecs[i].neg_v, vecs[i].lng_v, vecs[i].rep_v});
            end
         end
         for (int ch = 0; ch < 4; ch++) begin
            pos_cnt[ch] += int'(btn_posedge[ch]);
            neg_cnt[ch] += int'(btn_negedge[ch]);
            lng_cnt[ch] += int'(btn_long[ch]);
            rep_cnt[ch] += int'(btn_repeat[ch]);
         end
      end
      chk("tot_pos", sid, ncyc, {4'h0, pack(pos_cnt)}, {4'h0, exp_pos});
      chk("tot_neg", sid, ncyc, {4'h0, pack(neg_cnt)}, {4'h0, exp_neg});
      chk("tot_long", sid, ncyc, {4'h0, pack(lng_cnt)}, {4'h0, exp_lng});
      chk("tot_rep", sid, ncyc, {4'h0, pack(rep_cnt)}, {4'h0, exp_rep});
   endtask

   initial begin
      // Scenario 1: ch0 clean step then release (out falls at 27), ch1 7-cycle
      // glitch, ch2 held (long at 29, repeat 34/39/44), ch3 released so its
      // output falls exactly on the cycle the long pulse would have fired.
      //   sid cyc drv in       out      pos      neg      long     rep
      add(1,  0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1,  7, 1, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1,  9, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 10, 0, 4'b0000, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
      add(1, 11, 0, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 17, 1, 4'b1100, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 19, 1, 4'b0100, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 26, 0, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 27, 0, 4'b0000, 4'b1100, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 28, 0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 29, 0, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b0000);
      add(1, 30, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 33, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 34, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      add(1, 35, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 39, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      add(1, 44, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      // Scenario 2: all channels rise together, fall after 3, 8, 12, 7 cycles.
      add(2,  0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2,  3, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2,  7, 1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2,  8, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2,  9, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2, 10, 0, 4'b0000, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
      add(2, 11, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2, 12, 1, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2, 17, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2, 18, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      add(2, 19, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2, 21, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(2, 22, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      add(2, 23, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Reset state while rst_n is low.
      #12;
      chk("reset_state", 0, 0, snap(), 20'h0);

      do_reset();
      run_scenario(1, 46, 16'h1101, 16'h1001, 16'h0100, 16'h0300);
      do_reset();
      run_scenario(2, 30, 16'h0110, 16'h0110, 16'h0000, 16'h0000);

      // Scenario 3: asynchronous reset mid-hold, released with inputs still high.
      do_reset();
      for (int c = 0; c <= 46; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) btn_in = 4'hF;
         if (c == 15) begin
            #1;
            chk("pre_reset", 3, c, snap(), {4'hF, 16'h0});
            rst_n = 1'b0;
            #1;
            chk("async_reset", 3, c, snap(), 20'h0);
         end
         if (c == 17) begin
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
         if (c == 16) chk("in_reset", 3, c, snap(), 20'h0);
         if (c == 26) chk("rel_pre", 3, c, snap(), 20'h0);
         if (c == 27) chk("rel_pos", 3, c, snap(), {4'hF, 4'hF, 12'h0});
         if (c == 29) chk("no_old_long", 3, c, snap(), {4'hF, 16'h0});
         if (c == 45) chk("pre_long", 3, c, snap(), {4'hF, 16'h0});
         if (c == 46) chk("new_long", 3, c, snap(), {4'hF, 4'h0, 4'h0, 4'hF, 4'h0});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
